// File: rtl/nx_host_stream.sv
// Host-side bridge for the mesh: host-to-mesh skid buffer, mesh-to-host FIFO,
// message counters and a trigger sequencer that steps the mesh a requested number of cycles.
module nx_host_stream #(
    parameter int STREAM_WIDTH = 32,
    parameter int RX_DEPTH     = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] host_tx_data_i,
    input  logic                    host_tx_valid_i,
    output logic                    host_tx_ready_o,
    output logic [STREAM_WIDTH-1:0] mesh_ib_data_o,
    output logic                    mesh_ib_valid_o,
    input  logic                    mesh_ib_ready_i,
    input  logic [STREAM_WIDTH-1:0] mesh_ob_data_i,
    input  logic                    mesh_ob_valid_i,
    output logic                    mesh_ob_ready_o,
    output logic [STREAM_WIDTH-1:0] host_rx_data_o,
    output logic                    host_rx_valid_o,
    input  logic                    host_rx_ready_i,
    output logic                    mesh_trigger_o,
    input  logic                    mesh_idle_i,
    input  logic                    start_i,
    input  logic [COUNT_WIDTH-1:0]  cycles_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [COUNT_WIDTH-1:0]  tx_count_o,
    output logic [COUNT_WIDTH-1:0]  rx_count_o
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] RX_FULL_LEVEL = (AW+1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_TRIGGER,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // TX skid buffer: output slot drives the mesh, skid slot catches the
    // word accepted while the output slot is stalled.
    // ------------------------------------------------------------------
    logic                    ib_valid_reg, ib_valid_next;
    logic [STREAM_WIDTH-1:0] ib_data_reg, ib_data_next;
    logic                    skid_valid_reg, skid_valid_next;
    logic [STREAM_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                    tx_accept;
    logic                    ib_fire;
    logic                    tx_empty;

    assign host_tx_ready_o = !skid_valid_reg;
    assign tx_accept       = host_tx_valid_i && host_tx_ready_o;
    assign ib_fire         = ib_valid_reg && mesh_ib_ready_i;
    assign tx_empty        = !ib_valid_reg && !skid_valid_reg;
    assign mesh_ib_valid_o = ib_valid_reg;
    assign mesh_ib_data_o  = ib_data_reg;

    always_comb begin
        ib_valid_next   = ib_valid_reg;
        ib_data_next    = ib_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (!ib_valid_reg || mesh_ib_ready_i) begin
            if (skid_valid_reg) begin
                ib_valid_next   = 1'b1;
                ib_data_next    = skid_data_reg;
                skid_valid_next = 1'b0;
            end else begin
                ib_valid_next = tx_accept;
                if (tx_accept) begin
                    ib_data_next = host_tx_data_i;
                end
            end
        end else if (tx_accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = host_tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ib_valid_reg   <= 1'b0;
            ib_data_reg    <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            ib_valid_reg   <= ib_valid_next;
            ib_data_reg    <= ib_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO: pointers carry one extra bit so full and empty differ.
    // ------------------------------------------------------------------
    logic [STREAM_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [AW:0]             wr_ptr_reg, wr_ptr_next;
    logic [AW:0]             rd_ptr_reg, rd_ptr_next;
    logic [AW:0]             rx_level;
    logic                    rx_full;
    logic                    rx_empty;
    logic                    rx_push;
    logic                    rx_pop;

    assign rx_level        = wr_ptr_reg - rd_ptr_reg;
    assign rx_full         = (rx_level == RX_FULL_LEVEL);
    assign rx_empty        = (rx_level == '0);
    assign mesh_ob_ready_o = !rx_full;
    assign host_rx_valid_o = !rx_empty;
    assign rx_push         = mesh_ob_valid_i && !rx_full;
    assign rx_pop          = host_rx_ready_i && !rx_empty;
    assign wr_ptr_next     = rx_push ? wr_ptr_reg + (AW+1)'(1) : wr_ptr_reg;
    assign rd_ptr_next     = rx_pop  ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;
    // Head is masked while empty so stale entries never reach the host bus.
    assign host_rx_data_o  = rx_empty ? '0 : rx_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem[wr_ptr_reg[AW-1:0]] <= mesh_ob_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Message counters
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0] tx_count_reg;
    logic [COUNT_WIDTH-1:0] rx_count_reg;

    assign tx_count_o = tx_count_reg;
    assign rx_count_o = rx_count_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_count_reg <= '0;
            rx_count_reg <= '0;
        end else begin
            if (ib_fire) begin
                tx_count_reg <= tx_count_reg + COUNT_WIDTH'(1);
            end
            if (rx_push) begin
                rx_count_reg <= rx_count_reg + COUNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger sequencer
    // ------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [COUNT_WIDTH-1:0] remaining_reg, remaining_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    if (cycles_i != '0) begin
                        remaining_next = cycles_i;
                        state_next     = ST_WAIT_IDLE;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A trigger only fires once every queued host word has reached the mesh.
                if (remaining_reg == '0) begin
                    state_next = ST_DONE;
                end else if (mesh_idle_i && tx_empty) begin
                    state_next = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                remaining_next = remaining_reg - COUNT_WIDTH'(1);
                state_next     = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_next = ST_WAIT_IDLE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mesh_trigger_o = (state_reg == ST_TRIGGER);
    assign done_o         = (state_reg == ST_DONE);
    assign busy_o         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_nx_host_stream.sv
// Directed bench for nx_host_stream: TX skid, RX FIFO full handling, sequencer runs and reset abort.
module tb_nx_host_stream;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] host_tx_data_i;
    logic        host_tx_valid_i;
    logic        host_tx_ready_o;
    logic [31:0] mesh_ib_data_o;
    logic        mesh_ib_valid_o;
    logic        mesh_ib_ready_i;
    logic [31:0] mesh_ob_data_i;
    logic        mesh_ob_valid_i;
    logic        mesh_ob_ready_o;
    logic [31:0] host_rx_data_o;
    logic        host_rx_valid_o;
    logic        host_rx_ready_i;
    logic        mesh_trigger_o;
    logic        mesh_idle_i;
    logic        start_i;
    logic [15:0] cycles_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] tx_count_o;
    logic [15:0] rx_count_o;

    int checks;
    int failures;

    nx_host_stream dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .host_tx_data_i (host_tx_data_i),
        .host_tx_valid_i(host_tx_valid_i),
        .host_tx_ready_o(host_tx_ready_o),
        .mesh_ib_data_o (mesh_ib_data_o),
        .mesh_ib_valid_o(mesh_ib_valid_o),
        .mesh_ib_ready_i(mesh_ib_ready_i),
        .mesh_ob_data_i (mesh_ob_data_i),
        .mesh_ob_valid_i(mesh_ob_valid_i),
        .mesh_ob_ready_o(mesh_ob_ready_o),
        .host_rx_data_o (host_rx_data_o),
        .host_rx_valid_o(host_rx_valid_o),
        .host_rx_ready_i(host_rx_ready_i),
        .mesh_trigger_o (mesh_trigger_o),
        .mesh_idle_i    (mesh_idle_i),
        .start_i        (start_i),
        .cycles_i       (cycles_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .tx_count_o     (tx_count_o),
        .rx_count_o     (rx_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic test_reset();
        rst_i           = 1'b0;
        host_tx_data_i  = '0;
        host_tx_valid_i = 1'b0;
        mesh_ib_ready_i = 1'b1;
        mesh_ob_data_i  = '0;
        mesh_ob_valid_i = 1'b0;
        host_rx_ready_i = 1'b0;
        mesh_idle_i     = 1'b1;
        start_i         = 1'b0;
        cycles_i        = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (host_tx_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx_ready: got %b expected 1", host_tx_ready_o);
        end
        checks++;
        if (mesh_ob_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ob_ready: got %b expected 1", mesh_ob_ready_o);
        end
        checks++;
        if ({mesh_ib_valid_o, host_rx_valid_o, mesh_trigger_o, busy_o, done_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {mesh_ib_valid_o, host_rx_valid_o, mesh_trigger_o, busy_o, done_o});
        end
        checks++;
        if ({mesh_ib_data_o, host_rx_data_o, tx_count_o, rx_count_o} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: ib=%h rx=%h txc=%0d rxc=%0d expected all 0",
                     mesh_ib_data_o, host_rx_data_o, tx_count_o, rx_count_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_tx_stream();
        logic [31:0] host_d [8];
        logic [31:0] exp_d [8];
        logic [7:0]  host_v;
        logic [7:0]  mesh_r;
        logic [7:0]  exp_v;
        logic [7:0]  exp_hr;
        host_d = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        exp_d  = '{32'h0, 32'h11, 32'h22, 32'h22, 32'h22, 32'h22, 32'h33, 32'h0};
        host_v = 8'b0000_0111;
        mesh_r = 8'b1110_0011;
        exp_v  = 8'b0111_1110;
        exp_hr = 8'b1100_0111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            host_tx_valid_i = host_v[c];
            host_tx_data_i  = host_d[c];
            mesh_ib_ready_i = mesh_r[c];
            #1;
            checks++;
            if (mesh_ib_valid_o !== exp_v[c]) begin
                failures++;
                $display("FAIL tx_ib_valid c%0d: got %b expected %b", c, mesh_ib_valid_o, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (mesh_ib_data_o !== exp_d[c]) begin
                    failures++;
                    $display("FAIL tx_ib_data c%0d: got %h expected %h", c, mesh_ib_data_o, exp_d[c]);
                end
            end
            checks++;
            if (host_tx_ready_o !== exp_hr[c]) begin
                failures++;
                $display("FAIL tx_host_ready c%0d: got %b expected %b", c, host_tx_ready_o, exp_hr[c]);
            end
            if (mesh_ib_valid_o && mesh_ib_ready_i)
                $display("tx handshake c%0d data=%h", c, mesh_ib_data_o);
        end
        checks++;
        if (tx_count_o !== 16'd3) begin
            failures++;
            $display("FAIL tx_count: got %0d expected 3", tx_count_o);
        end
        host_tx_valid_i = 1'b0;
        mesh_ib_ready_i = 1'b1;
    endtask

    task automatic test_rx_full();
        logic [31:0] push_d [11];
        logic [31:0] exp_d [11];
        logic [10:0] push_v;
        logic [10:0] pop_r;
        logic [10:0] exp_obr;
        logic [10:0] exp_rv;
        push_d  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        exp_d   = '{32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
        push_v  = 11'b000_0011_1111;
        pop_r   = 11'b011_1101_0000;
        exp_obr = 11'b111_1010_1111;
        exp_rv  = 11'b011_1111_1110;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk_i);
            mesh_ob_valid_i = push_v[c];
            mesh_ob_data_i  = push_d[c];
            host_rx_ready_i = pop_r[c];
            #1;
            checks++;
            if (mesh_ob_ready_o !== exp_obr[c]) begin
                failures++;
                $display("FAIL rx_ob_ready c%0d: got %b expected %b", c, mesh_ob_ready_o, exp_obr[c]);
            end
            checks++;
            if (host_rx_valid_o !== exp_rv[c]) begin
                failures++;
                $display("FAIL rx_valid c%0d: got %b expected %b", c, host_rx_valid_o, exp_rv[c]);
            end
            if (exp_rv[c]) begin
                checks++;
                if (host_rx_data_o !== exp_d[c]) begin
                    failures++;
                    $display("FAIL rx_data c%0d: got %h expected %h", c, host_rx_data_o, exp_d[c]);
                end
            end
            if (c == 6) begin
                checks++;
                if (rx_count_o !== 16'd5) begin
                    failures++;
                    $display("FAIL rx_count_full: got %0d expected 5", rx_count_o);
                end
            end
            if (host_rx_valid_o && host_rx_ready_i)
                $display("rx pop c%0d data=%h", c, host_rx_data_o);
        end
        mesh_ob_valid_i = 1'b0;
        host_rx_ready_i = 1'b0;
    endtask

    task automatic test_run();
        int trig_cyc[$];
        int done_cyc[$];
        int idle_low;
        logic exp_busy;
        idle_low = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            start_i     = (c < 5);
            cycles_i    = (c == 0) ? 16'd3 : 16'd7;
            mesh_idle_i = (idle_low == 0);
            if (idle_low > 0) idle_low--;
            #1;
            if (mesh_trigger_o) begin
                trig_cyc.push_back(c);
                idle_low = 2;
                $display("run trigger c%0d", c);
            end
            if (done_o) done_cyc.push_back(c);
            exp_busy = (c >= 1 && c <= 13);
            checks++;
            if (busy_o !== exp_busy) begin
                failures++;
                $display("FAIL run_busy c%0d: got %b expected %b", c, busy_o, exp_busy);
            end
        end
        start_i     = 1'b0;
        mesh_idle_i = 1'b1;
        checks++;
        if (trig_cyc.size() != 3) begin
            failures++;
            $display("FAIL run_trigger_count: got %0d expected 3", trig_cyc.size());
        end else begin
            checks++;
            if (trig_cyc[0] != 2 || trig_cyc[1] != 6 || trig_cyc[2] != 10) begin
                failures++;
                $display("FAIL run_trigger_cycles: got %0d,%0d,%0d expected 2,6,10",
                         trig_cyc[0], trig_cyc[1], trig_cyc[2]);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            failures++;
            $display("FAIL run_done_count: got %0d expected 1", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != 13) begin
                failures++;
                $display("FAIL run_done_cycle: got %0d expected 13", done_cyc[0]);
            end
        end
    endtask

    task automatic test_zero_run();
        logic [2:0] exp_busy;
        logic [2:0] exp_done;
        exp_busy = 3'b010;
        exp_done = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            start_i  = (c == 0);
            cycles_i = '0;
            #1;
            checks++;
            if ({busy_o, done_o, mesh_trigger_o} !== {exp_busy[c], exp_done[c], 1'b0}) begin
                failures++;
                $display("FAIL zero_run c%0d: busy/done/trig got %b%b%b expected %b%b0",
                         c, busy_o, done_o, mesh_trigger_o, exp_busy[c], exp_done[c]);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_gating();
        int trig_cyc[$];
        int done_cyc[$];
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_i);
            host_tx_valid_i = (c == 0);
            host_tx_data_i  = 32'h55;
            mesh_ib_ready_i = (c >= 7);
            start_i         = (c == 1);
            cycles_i        = 16'd1;
            mesh_idle_i     = 1'b1;
            #1;
            if (mesh_trigger_o) trig_cyc.push_back(c);
            if (done_o) done_cyc.push_back(c);
            if (c == 6) begin
                checks++;
                if (mesh_ib_valid_o !== 1'b1 || mesh_ib_data_o !== 32'h55) begin
                    failures++;
                    $display("FAIL gate_hold: valid=%b data=%h expected 1/00000055",
                             mesh_ib_valid_o, mesh_ib_data_o);
                end
            end
        end
        host_tx_valid_i = 1'b0;
        start_i         = 1'b0;
        checks++;
        if (trig_cyc.size() != 1) begin
            failures++;
            $display("FAIL gate_trigger_count: got %0d expected 1", trig_cyc.size());
        end else begin
            checks++;
            if (trig_cyc[0] != 9) begin
                failures++;
                $display("FAIL gate_trigger_cycle: got %0d expected 9", trig_cyc[0]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 12) begin
            failures++;
            $display("FAIL gate_done: got %0d pulses first=%0d expected 1 at 12",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        checks++;
        if (tx_count_o !== 16'd4) begin
            failures++;
            $display("FAIL gate_tx_count: got %0d expected 4", tx_count_o);
        end
    endtask

    task automatic test_reset_mid_run();
        bit got_trig;
        bit done_seen;
        got_trig  = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            mesh_ob_valid_i = 1'b1;
            mesh_ob_data_i  = 32'hB0 + c;
            host_rx_ready_i = 1'b0;
        end
        @(negedge clk_i);
        mesh_ob_valid_i = 1'b0;
        mesh_ib_ready_i = 1'b0;
        start_i         = 1'b1;
        cycles_i        = 16'd2;
        mesh_idle_i     = 1'b1;
        for (int c = 0; c < 10 && !got_trig; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            if (mesh_trigger_o) begin
                got_trig        = 1'b1;
                host_tx_valid_i = 1'b1;
                host_tx_data_i  = 32'h77;
            end
        end
        checks++;
        if (!got_trig) begin
            failures++;
            $display("FAIL mid_reset_trigger: no trigger within 10 cycles");
        end
        @(negedge clk_i);
        host_tx_valid_i = 1'b0;
        #1;
        checks++;
        if ({host_rx_valid_o, mesh_ib_valid_o, busy_o} !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset_pre: rxv/ibv/busy got %b expected 111",
                     {host_rx_valid_o, mesh_ib_valid_o, busy_o});
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if ({host_tx_ready_o, mesh_ob_ready_o, mesh_ib_valid_o, host_rx_valid_o,
             mesh_trigger_o, busy_o, done_o} !== 7'b1100000) begin
            failures++;
            $display("FAIL mid_reset_flags: got %b expected 1100000",
                     {host_tx_ready_o, mesh_ob_ready_o, mesh_ib_valid_o, host_rx_valid_o,
                      mesh_trigger_o, busy_o, done_o});
        end
        checks++;
        if ({mesh_ib_data_o, host_rx_data_o, tx_count_o, rx_count_o} !== 96'h0) begin
            failures++;
            $display("FAIL mid_reset_data: ib=%h rx=%h txc=%0d rxc=%0d expected all 0",
                     mesh_ib_data_o, host_rx_data_o, tx_count_o, rx_count_o);
        end
        mesh_ib_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (done_o) done_seen = 1'b1;
        end
        rst_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            #1;
            if (done_o || busy_o || mesh_ib_valid_o || host_rx_valid_o) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            failures++;
            $display("FAIL mid_reset_after: done/busy/pending activity seen after abort, expected none");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tx_stream();
        test_rx_full();
        test_run();
        test_zero_run();
        test_gating();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nx_host_stream.md
NX_HOST_STREAM -- requirements
Module: nx_host_stream

Interface
REQ-001 Parameter STREAM_WIDTH SHALL default to 32 and set the message width on every stream port.
REQ-002 Parameter RX_DEPTH SHALL default to 4 and set the mesh-to-host FIFO depth; legal values are powers of two, 2 or more.
REQ-003 Parameter COUNT_WIDTH SHALL default to 16 and set the width of the cycle request and the message counters.
REQ-004 The ports SHALL be exactly as listed below, clock and reset first.
- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_i  input  1  reset; asynchronous assert, active-low.
- host_tx_data_i  input  STREAM_WIDTH  message from host to mesh.
- host_tx_valid_i  input  1  host_tx_data_i is valid.
- host_tx_ready_o  output  1  block accepts host_tx_data_i.
- mesh_ib_data_o  output  STREAM_WIDTH  drives the mesh inbound stream.
- mesh_ib_valid_o  output  1  mesh_ib_data_o is valid.
- mesh_ib_ready_i  input  1  mesh accepts mesh_ib_data_o.
- mesh_ob_data_i  input  STREAM_WIDTH  message from the mesh outbound stream.
- mesh_ob_valid_i  input  1  mesh_ob_data_i is valid.
- mesh_ob_ready_o  output  1  block accepts mesh_ob_data_i.
- host_rx_data_o  output  STREAM_WIDTH  message from mesh to host.
- host_rx_valid_o  output  1  host_rx_data_o is valid.
- host_rx_ready_i  input  1  host accepts host_rx_data_o.
- mesh_trigger_o  output  1  one-cycle trigger pulse to the mesh.
- mesh_idle_i  input  1  AND of all node idle flags.
- start_i  input  1  request a run of cycles_i mesh cycles.
- cycles_i  input  COUNT_WIDTH  number of triggers to issue.
- busy_o  output  1  run in progress.
- done_o  output  1  one-cycle pulse at the end of a run.
- tx_count_o  output  COUNT_WIDTH  messages delivered to the mesh.
- rx_count_o  output  COUNT_WIDTH  messages accepted from the mesh.

Function
REQ-005 The TX path SHALL be a 2-entry skid buffer, and mesh_ib_valid_o and mesh_ib_data_o SHALL come directly from flops.
REQ-006 host_tx_ready_o SHALL be 1 whenever the skid buffer holds fewer than 2 entries.
REQ-007 Once mesh_ib_valid_o is asserted, mesh_ib_data_o and mesh_ib_valid_o SHALL hold stable until mesh_ib_ready_i is sampled high.
REQ-008 The TX path SHALL sustain 1 message per cycle with a latency of 1 cycle from host acceptance to mesh_ib_valid_o.
REQ-009 The RX path SHALL be a RX_DEPTH-entry FIFO, with mesh_ob_ready_o equal to not-full.
REQ-010 host_rx_valid_o SHALL equal not-empty, and host_rx_data_o SHALL show the head entry.
REQ-011 A push and a pop in the same cycle SHALL leave the RX occupancy unchanged, including when the FIFO is full.
REQ-012 When the RX FIFO is full, a simultaneous pop SHALL NOT raise mesh_ob_ready_o in that same cycle.
REQ-013 The RX read and write pointers SHALL wrap modulo RX_DEPTH.
REQ-014 tx_count_o SHALL increment on each mesh_ib handshake, and rx_count_o SHALL increment on each mesh_ob handshake.
REQ-015 tx_count_o and rx_count_o SHALL wrap modulo 2^COUNT_WIDTH.
REQ-016 The sequencer FSM SHALL have the states IDLE, WAIT_IDLE, TRIGGER, SETTLE and DONE.
REQ-017 In IDLE, when start_i=1 and cycles_i!=0, the FSM SHALL latch cycles_i into remaining and go to WAIT_IDLE.
REQ-018 In IDLE, when start_i=1 and cycles_i=0, the FSM SHALL go to DONE.
REQ-019 In WAIT_IDLE, when remaining=0, the FSM SHALL go to DONE.
REQ-020 In WAIT_IDLE, when mesh_idle_i=1, the TX buffer is empty and remaining!=0, the FSM SHALL go to TRIGGER.
REQ-021 In TRIGGER, mesh_trigger_o SHALL be 1 for exactly that one cycle, remaining SHALL decrement, and the FSM SHALL go to SETTLE.
REQ-022 SETTLE SHALL last exactly 1 cycle and then go to WAIT_IDLE.
REQ-023 DONE SHALL assert done_o for exactly that one cycle and then go to IDLE.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 start_i SHALL be ignored outside IDLE.
REQ-026 The stream paths SHALL keep operating in every FSM state.

Reset
REQ-027 While rst_i=0, all outputs SHALL be 0 except host_tx_ready_o=1 and mesh_ob_ready_o=1.
REQ-028 While rst_i=0, the FSM SHALL be in IDLE and both FIFOs and both counters SHALL be cleared.
REQ-029 Asserting rst_i mid-run or mid-transfer SHALL abort immediately, with no done_o pulse and no pending message delivered.
REQ-030 Leaving reset SHALL be synchronous: the first state update occurs on the first clk_i edge with rst_i=1.

Verification
REQ-031 TX stream: host sends 0x11,0x22,0x33 back-to-back; mesh_ib_ready_i is low for cycles 2-4 -> mesh sees 0x11,0x22,0x33 in order with data stable while stalled, and tx_count_o=3.
REQ-032 RX full: mesh pushes 5 words with host_rx_ready_i=0 and RX_DEPTH=4 -> mesh_ob_ready_o=0 after 4 words; after host pops 1 word, the 5th word is accepted; rx_count_o=5.
REQ-033 Run: start_i with cycles_i=3 and mesh_idle_i low 2 cycles after each trigger -> exactly 3 mesh_trigger_o pulses, each at least 4 cycles apart, then one done_o pulse, then busy_o=0.
REQ-034 Zero run: start_i with cycles_i=0 -> done_o is asserted on the next cycle, with no trigger and busy_o high for 1 cycle.
REQ-035 Gating: the TX buffer holds a word that mesh_ib_ready_i=0 is blocking during WAIT_IDLE -> no trigger until that word drains.
REQ-036 Reset: rst_i driven low in SETTLE while the RX FIFO holds 2 entries -> outputs immediately match REQ-027 and REQ-028, and no done_o pulse occurs.
